// File: rtl/sbox_scheduler_if.sv
// Request/result bundle between the AES round controller / key expander, the
// SBox scheduler and the shared SBox instance.
interface sbox_scheduler_if #(
  parameter int ST_BYTES = 16,
  parameter int KW_BYTES = 4
);
  logic                    i_st_valid;
  logic                    o_st_ready;
  logic [8*ST_BYTES-1:0]   i_st_data;
  logic                    o_st_done;
  logic [8*ST_BYTES-1:0]   o_st_result;
  logic                    i_kw_valid;
  logic                    o_kw_ready;
  logic [8*KW_BYTES-1:0]   i_kw_data;
  logic                    o_kw_done;
  logic [8*KW_BYTES-1:0]   o_kw_result;
  logic [7:0]              o_sbox_in;
  logic [7:0]              i_sbox_out;
  logic                    o_busy;

  modport slave (
    input  i_st_valid, i_st_data, i_kw_valid, i_kw_data, i_sbox_out,
    output o_st_ready, o_st_done, o_st_result,
    output o_kw_ready, o_kw_done, o_kw_result,
    output o_sbox_in, o_busy
  );

  modport master (
    output i_st_valid, i_st_data, i_kw_valid, i_kw_data, i_sbox_out,
    input  o_st_ready, o_st_done, o_st_result,
    input  o_kw_ready, o_kw_done, o_kw_result,
    input  o_sbox_in, o_busy
  );
endinterface

// File: rtl/sbox_scheduler.sv
// Time-shares one combinational SBox between the SubBytes state path and the
// key-expansion SubWord path, one byte per cycle, job-level round-robin.
module sbox_scheduler #(
  parameter int ST_BYTES = 16,
  parameter int KW_BYTES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  sbox_scheduler_if.slave  bus
);
  localparam int ST_W = 8 * ST_BYTES;
  localparam int KW_W = 8 * KW_BYTES;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN_ST = 2'd1;
  localparam logic [1:0] S_RUN_KW = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]      r_state;
  logic [3:0]      r_cnt;
  logic            r_last_kw;
  logic            r_fin_st;
  logic            r_st_done;
  logic            r_kw_done;
  logic [ST_W-1:0] r_st_result;
  logic [KW_W-1:0] r_kw_result;
  logic [ST_W-1:0] r_in_buf;
  logic [ST_W-1:0] r_res_buf;

  logic w_idle;
  logic w_run;
  logic w_grant_st;
  logic w_grant_kw;
  logic w_last_byte;

  assign w_idle = (r_state == S_IDLE);
  assign w_run  = (r_state == S_RUN_ST) || (r_state == S_RUN_KW);

  // On a tie the requester that was not served last wins; r_last_kw resets to 1
  // so the first tie goes to the state path.
  assign w_grant_st = w_idle && bus.i_st_valid && (!bus.i_kw_valid || r_last_kw);
  assign w_grant_kw = w_idle && bus.i_kw_valid && (!bus.i_st_valid || !r_last_kw);

  assign w_last_byte = ((r_state == S_RUN_ST) && (r_cnt == 4'(ST_BYTES - 1))) ||
                       ((r_state == S_RUN_KW) && (r_cnt == 4'(KW_BYTES - 1)));

  assign bus.o_st_ready  = w_grant_st;
  assign bus.o_kw_ready  = w_grant_kw;
  assign bus.o_sbox_in   = w_run ? r_in_buf[7:0] : 8'h00;
  assign bus.o_busy      = !w_idle;
  assign bus.o_st_done   = r_st_done;
  assign bus.o_kw_done   = r_kw_done;
  assign bus.o_st_result = r_st_result;
  assign bus.o_kw_result = r_kw_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_last_kw   <= 1'b1;
      r_fin_st    <= 1'b0;
      r_st_done   <= 1'b0;
      r_kw_done   <= 1'b0;
      r_st_result <= '0;
      r_kw_result <= '0;
    end else begin
      r_st_done <= 1'b0;
      r_kw_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_st) begin
            r_state   <= S_RUN_ST;
            r_cnt     <= 4'd0;
            r_last_kw <= 1'b0;
            r_fin_st  <= 1'b1;
          end else if (w_grant_kw) begin
            r_state   <= S_RUN_KW;
            r_cnt     <= 4'd0;
            r_last_kw <= 1'b1;
            r_fin_st  <= 1'b0;
          end
        end
        S_RUN_ST, S_RUN_KW: begin
          if (w_last_byte) begin
            r_state <= S_FINISH;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: begin
          if (r_fin_st) begin
            r_st_result <= r_res_buf;
            r_st_done   <= 1'b1;
          end else begin
            r_kw_result <= r_res_buf[KW_W-1:0];
            r_kw_done   <= 1'b1;
          end
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Byte buffers are pure datapath: the input is shifted down so byte 0 always
  // feeds the SBox, and each SBox result lands at the current byte position.
  always_ff @(posedge clk) begin
    if (w_grant_st) begin
      r_in_buf <= bus.i_st_data;
    end else if (w_grant_kw) begin
      r_in_buf <= {{(ST_W - KW_W){1'b0}}, bus.i_kw_data};
    end else if (w_run) begin
      r_in_buf <= r_in_buf >> 8;
    end
    if (w_run) begin
      r_res_buf[8*r_cnt +: 8] <= bus.i_sbox_out;
    end
  end
endmodule

// File: tb/tb_sbox_scheduler.sv
// Randomized self-checking bench for sbox_scheduler with a job-level reference
// model (per-byte SBox table, round-robin grant tracking, expected result regs).
module tb_sbox_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  logic prev_done = 1'b0;

  logic [127:0] exp_st = '0;
  logic [31:0]  exp_kw = '0;
  bit           last_kw = 1'b1;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  sbox_scheduler_if bus ();

  sbox_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] d, input int n);
    logic [127:0] r = '0;
    for (int k = 0; k < n; k++) r[8*k +: 8] = sbox(d[8*k +: 8]);
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always_comb bus.i_sbox_out = sbox(bus.o_sbox_in);

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_busy) chk("rdy_busy", {bus.o_st_ready, bus.o_kw_ready}, 2'b00);
      if (bus.i_st_valid && bus.i_kw_valid) chk("one_ready", bus.o_st_ready & bus.o_kw_ready, 1'b0);
      if (bus.o_st_done || bus.o_kw_done) chk("done_width", prev_done, 1'b0);
      prev_done <= bus.o_st_done | bus.o_kw_done;
    end else begin
      prev_done <= 1'b0;
    end
  end

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, bus.o_busy, 1'b0);
    chk({tag, "_done"}, {bus.o_st_done, bus.o_kw_done}, 2'b00);
    chk({tag, "_sbox"}, bus.o_sbox_in, 8'h00);
    chk({tag, "_st_res"}, bus.o_st_result, 128'h0);
    chk({tag, "_kw_res"}, bus.o_kw_result, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("rst");
    exp_st  = '0;
    exp_kw  = '0;
    last_kw = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at a negedge; returns right after the accept edge.
  task automatic wait_grant(output bit got_st, output logic [127:0] d, output int gc);
    bit ok = 1'b0;
    bit want_st;
    got_st = 1'b0;
    d = '0;
    gc = 0;
    for (int t = 0; t < 40 && !ok; t++) begin
      #1;
      if (bus.i_st_valid && bus.o_st_ready) begin
        got_st = 1'b1; ok = 1'b1;
      end else if (bus.i_kw_valid && bus.o_kw_ready) begin
        got_st = 1'b0; ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) begin
      chk("grant_timeout", 1'b0, 1'b1);
      finish_run();
    end
    want_st = bus.i_st_valid && (!bus.i_kw_valid || last_kw);
    chk("grant", got_st, want_st);
    last_kw = !got_st;
    d  = got_st ? bus.i_st_data : {96'h0, bus.i_kw_data};
    gc = cyc;
    @(posedge clk);
  endtask

  task automatic track(input bit is_st, input logic [127:0] d, input int gc,
                       input bit hold, input bit mut);
    int n;
    logic [127:0] res;
    n   = is_st ? 16 : 4;
    res = sub_bytes(d, n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) begin
        if (is_st) begin
          bus.i_st_data = rand128();
          if (!hold) bus.i_st_valid = 1'b0;
        end else begin
          bus.i_kw_data = $urandom;
          if (!hold) bus.i_kw_valid = 1'b0;
        end
      end
      if (mut && i == 2) begin
        bus.i_st_valid = 1'b1; bus.i_kw_valid = 1'b1;
        bus.i_st_data = rand128(); bus.i_kw_data = $urandom;
      end
      if (mut && i == 5) begin
        bus.i_st_valid = 1'b0; bus.i_kw_valid = 1'b0;
      end
      chk("sbox_in", bus.o_sbox_in, d[8*i +: 8]);
      chk("run_done", {bus.o_st_done, bus.o_kw_done}, 2'b00);
    end
    @(negedge clk);
    chk("fin_busy", bus.o_busy, 1'b1);
    chk("fin_sbox", bus.o_sbox_in, 8'h00);
    chk("fin_done", {bus.o_st_done, bus.o_kw_done}, 2'b00);
    @(negedge clk);
    if (is_st) exp_st = res;
    else       exp_kw = res[31:0];
    chk("done", {bus.o_st_done, bus.o_kw_done}, is_st ? 2'b10 : 2'b01);
    chk("st_result", bus.o_st_result, exp_st);
    chk("kw_result", bus.o_kw_result, exp_kw);
    chk("latency", cyc - gc, n + 2);
    chk("idle_busy", bus.o_busy, 1'b0);
  endtask

  initial begin
    bit g;
    logic [127:0] d;
    int gc;
    int prev_gc;
    int r;

    bus.i_st_valid = 1'b0;
    bus.i_kw_valid = 1'b0;
    bus.i_st_data  = '0;
    bus.i_kw_data  = '0;
    repeat (2) @(negedge clk);
    #1;
    chk_zero_outputs("por");
    chk("por_ready", {bus.o_st_ready, bus.o_kw_ready}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero_outputs("idle");

    // FIPS-197 round-1 state and a known SubWord vector
    bus.i_st_data  = 128'h00112233445566778899aabbccddeeff;
    bus.i_st_valid = 1'b1;
    wait_grant(g, d, gc);
    track(g, d, gc, 1'b0, 1'b0);
    chk("fips_state", bus.o_st_result, 128'h638293c31bfc33f5c4eeacea4bc12816);

    bus.i_kw_data  = 32'h09cf4f3c;
    bus.i_kw_valid = 1'b1;
    wait_grant(g, d, gc);
    track(g, d, gc, 1'b0, 1'b0);
    chk("fips_word", bus.o_kw_result, 32'h018a84eb);
    chk("st_kept", bus.o_st_result, 128'h638293c31bfc33f5c4eeacea4bc12816);

    // Both held after reset: ST first, then strict alternation
    do_reset();
    bus.i_st_valid = 1'b1; bus.i_kw_valid = 1'b1;
    bus.i_st_data  = rand128(); bus.i_kw_data = $urandom;
    for (int j = 0; j < 4; j++) begin
      wait_grant(g, d, gc);
      chk("alternate", g, (j % 2) == 0);
      track(g, d, gc, 1'b1, 1'b0);
    end
    bus.i_st_valid = 1'b0; bus.i_kw_valid = 1'b0;

    // Input churn while busy
    bus.i_st_data = rand128(); bus.i_st_valid = 1'b1;
    wait_grant(g, d, gc);
    track(g, d, gc, 1'b0, 1'b1);

    // Reset in the middle of a state job, at byte 7
    bus.i_st_data = rand128(); bus.i_st_valid = 1'b1;
    wait_grant(g, d, gc);
    for (int i = 0; i <= 7; i++) begin
      @(negedge clk);
      if (i == 0) bus.i_st_valid = 1'b0;
      chk("pre_rst_sbox", bus.o_sbox_in, d[8*i +: 8]);
    end
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("mid_rst");
    exp_st = '0; exp_kw = '0; last_kw = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_done", {bus.o_st_done, bus.o_kw_done}, 2'b00);
    end
    rst_n = 1'b1;
    bus.i_st_data = rand128(); bus.i_st_valid = 1'b1;
    wait_grant(g, d, gc);
    track(g, d, gc, 1'b0, 1'b0);

    // Back-to-back key-word jobs with valid held
    bus.i_kw_data = $urandom; bus.i_kw_valid = 1'b1;
    prev_gc = 0;
    for (int j = 0; j < 3; j++) begin
      wait_grant(g, d, gc);
      if (j > 0) chk("b2b_spacing", gc - prev_gc, 6);
      prev_gc = gc;
      track(g, d, gc, 1'b1, 1'b0);
    end
    bus.i_kw_valid = 1'b0;

    // Random mix of single and contending requests
    for (int j = 0; j < 20; j++) begin
      r = int'($urandom_range(1, 3));
      bus.i_st_valid = r[0];
      bus.i_kw_valid = r[1];
      bus.i_st_data  = rand128();
      bus.i_kw_data  = $urandom;
      wait_grant(g, d, gc);
      track(g, d, gc, 1'b0, 1'b0);
    end
    bus.i_st_valid = 1'b0; bus.i_kw_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("end_idle", bus.o_busy, 1'b0);
    finish_run();
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
